// File: rtl/conv_window_ctrl.sv
// Line-buffer sequencer for a KxK convolution over a channel-interleaved pixel stream.
// Tracks ch/col/row position, gates the shift rows and flags beats that complete a full window.
module conv_window_ctrl #(
  parameter int unsigned IMG_W  = 200,
  parameter int unsigned IMG_H  = 200,
  parameter int unsigned K      = 3,
  parameter int unsigned CH     = 6,
  parameter int unsigned DATA_W = 16,
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int unsigned CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_sr_en,
  output logic [DATA_W-1:0] o_sr_data,
  output logic              o_win_valid,
  input  logic              i_win_ready,
  output logic [ROW_W-1:0]  o_win_row,
  output logic [COL_W-1:0]  o_win_col,
  output logic [CH_W-1:0]   o_win_ch,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CH - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] FILL_ROW = ROW_W'((K >= 2) ? K - 2 : 0);
  localparam logic [ROW_W-1:0] MIN_ROW  = ROW_W'(K - 1);
  localparam logic [COL_W-1:0] MIN_COL  = COL_W'(K - 1);

  typedef enum logic [1:0] {StIdle, StFill, StRun, StDone} state_e;

  state_e             r_state;
  logic [CH_W-1:0]    r_ch;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic               r_win_valid;
  logic [ROW_W-1:0]   r_win_row;
  logic [COL_W-1:0]   r_win_col;
  logic [CH_W-1:0]    r_win_ch;
  logic               r_done;

  logic w_stall;
  logic w_in_ready;
  logic w_accept;
  logic w_last_ch;
  logic w_last_col;
  logic w_row_end;
  logic w_frame_last;
  logic w_fill_last;
  logic w_qualify;

  // A pending, unconsumed window freezes the input so no beat is lost or duplicated.
  assign w_stall      = r_win_valid & ~i_win_ready;
  assign w_in_ready   = ((r_state == StFill) || (r_state == StRun)) & ~w_stall;
  assign w_accept     = i_in_valid & w_in_ready;
  assign w_last_ch    = (r_ch == LAST_CH);
  assign w_last_col   = (r_col == LAST_COL);
  assign w_row_end    = w_accept & w_last_ch & w_last_col;
  assign w_frame_last = w_row_end & (r_row == LAST_ROW);
  assign w_fill_last  = w_row_end & (r_row == FILL_ROW);
  assign w_qualify    = w_accept & (r_row >= MIN_ROW) & (r_col >= MIN_COL);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_ch        <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
      r_win_ch    <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state <= (K == 1) ? StRun : StFill;
            r_ch    <= '0;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        StFill: begin
          if (w_frame_last) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end else if (w_fill_last) begin
            r_state <= StRun;
          end
        end
        StRun: begin
          if (w_frame_last) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase

      if (w_accept) begin
        if (w_last_ch) begin
          r_ch <= '0;
          if (w_last_col) begin
            r_col <= '0;
            r_row <= (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
          end else begin
            r_col <= r_col + COL_W'(1);
          end
        end else begin
          r_ch <= r_ch + CH_W'(1);
        end
      end

      // A qualifying accept can only occur when no window is stalled, so reloading is safe.
      if (w_qualify) begin
        r_win_valid <= 1'b1;
        r_win_row   <= r_row;
        r_win_col   <= r_col;
        r_win_ch    <= r_ch;
      end else if (r_win_valid && i_win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_sr_en     = w_accept;
  assign o_sr_data   = i_in_data;
  assign o_win_valid = r_win_valid;
  assign o_win_row   = r_win_row;
  assign o_win_col   = r_win_col;
  assign o_win_ch    = r_win_ch;
  assign o_busy      = (r_state != StIdle);
  assign o_done      = r_done;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Randomised bench for conv_window_ctrl: window order, latency, stalls and frame framing are
// compared against a frame-enumeration model built from plain index arithmetic.
module tb_conv_window_ctrl;

  localparam int unsigned W   = 5;
  localparam int unsigned H   = 4;
  localparam int unsigned KS  = 3;
  localparam int unsigned C   = 2;
  localparam int unsigned DW  = 16;
  localparam int          F    = W * H * C;
  localparam int          NWIN = (H - KS + 1) * (W - KS + 1) * C;
  localparam int          TMO  = 2000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          sr_en;
  logic [DW-1:0] sr_data;
  logic          win_valid;
  logic          win_ready = 1'b1;
  logic [1:0]    win_row;
  logic [2:0]    win_col;
  logic [0:0]    win_ch;
  logic          busy;
  logic          done;

  conv_window_ctrl #(
    .IMG_W (W),
    .IMG_H (H),
    .K     (KS),
    .CH    (C),
    .DATA_W(DW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_in_valid (in_valid),
    .i_in_data  (in_data),
    .o_in_ready (in_ready),
    .o_sr_en    (sr_en),
    .o_sr_data  (sr_data),
    .o_win_valid(win_valid),
    .i_win_ready(win_ready),
    .o_win_row  (win_row),
    .o_win_col  (win_col),
    .o_win_ch   (win_ch),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Position packed as {row, col, ch}, one byte each.
  function automatic logic [31:0] pos_of(input int n);
    int r, c, h;
    r = n / (C * W);
    c = (n / C) % W;
    h = n % C;
    return {8'd0, 8'(r), 8'(c), 8'(h)};
  endfunction

  function automatic bit qualifies(input int n);
    return ((n / (C * W)) >= KS - 1) && (((n / C) % W) >= KS - 1);
  endfunction

  logic [31:0] cur_pos;
  assign cur_pos = {8'd0, 8'(win_row), 8'(win_col), 8'(win_ch)};

  logic [31:0] exp_q[$];
  bit          mon_en = 1'b0;
  int          beat_idx, win_got, done_cnt, cyc_mon, first_acc, last_acc_cyc;
  bit          prev_valid, prev_ready, exp_flag, last_acc;
  logic [31:0] prev_pos, exp_pos;

  always @(negedge clk) begin
    cyc_mon++;
    if (mon_en) begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 32'(win_valid), 1);
        check("hold_pos", cur_pos, prev_pos);
      end
      if (exp_flag) begin
        check("lat_valid", 32'(win_valid), 1);
        check("lat_pos", cur_pos, exp_pos);
      end
      exp_flag = 1'b0;
      if (last_acc) check("done_lat", 32'(done), 1);
      last_acc = 1'b0;
      if (done) begin
        done_cnt++;
        check("done_beats", beat_idx, F);
      end
      if (!busy) check("idle_rdy", 32'(in_ready), 0);
      if (win_valid && !win_ready) begin
        check("stall_rdy", 32'(in_ready), 0);
        check("stall_sr", 32'(sr_en), 0);
      end
      if (win_valid && win_ready) begin
        win_got++;
        if (exp_q.size() == 0) check("win_extra", cur_pos, 32'hffff_ffff);
        else check("win_seq", cur_pos, exp_q.pop_front());
      end
      if (sr_en) begin
        check("sr_data", 32'(sr_data), 32'(in_data));
        if (beat_idx >= F) begin
          check("beat_extra", beat_idx, F - 1);
        end else begin
          if (qualifies(beat_idx)) begin
            exp_flag = 1'b1;
            exp_pos  = pos_of(beat_idx);
          end
          if (first_acc < 0) first_acc = cyc_mon;
          last_acc_cyc = cyc_mon;
          beat_idx++;
          if (beat_idx == F) last_acc = 1'b1;
        end
      end
      prev_valid = win_valid;
      prev_ready = win_ready;
      prev_pos   = cur_pos;
    end
  end

  task automatic new_frame();
    exp_q.delete();
    for (int n = 0; n < F; n++) if (qualifies(n)) exp_q.push_back(pos_of(n));
    beat_idx  = 0;
    win_got   = 0;
    done_cnt  = 0;
    first_acc = -1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int vpct, input bit rnd_rdy, input bit bp, input bit extra_start);
    int cyc, bp_cnt;
    new_frame();
    cyc    = 0;
    bp_cnt = 0;
    while (!(done_cnt > 0 && win_got == NWIN && !win_valid) && cyc < TMO) begin
      in_valid  = ($urandom_range(99) < vpct);
      in_data   = DW'($urandom);
      win_ready = rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
      if (bp && win_valid && bp_cnt < 5) begin
        win_ready = 1'b0;
        bp_cnt++;
      end
      start = extra_start && (cyc == 10 || cyc == 30);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    win_ready = 1'b1;
    start     = 1'b0;
    @(posedge clk); #1;
    check("frame_timeout", 32'(cyc < TMO), 1);
    check("beats", beat_idx, F);
    check("windows", win_got, NWIN);
    check("done_pulses", done_cnt, 1);
    check("busy_after", 32'(busy), 0);
    if (bp) check("bp_cycles", bp_cnt, 5);
    if (vpct == 100 && !rnd_rdy && !bp) check("accept_span", last_acc_cyc - first_acc, F - 1);
  endtask

  initial begin
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready), 0);
    check("rst_valid", 32'(win_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pos", cur_pos, 0);
    check("rst_done", 32'(done), 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    mon_en   = 1'b1;

    run_frame(100, 1'b0, 1'b0, 1'b0);
    run_frame(100, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) run_frame(50, 1'b1, 1'b0, 1'b0);
    run_frame(100, 1'b0, 1'b0, 1'b1);
    run_frame(70, 1'b1, 1'b0, 1'b0);

    // Abort a frame with a window pending.
    new_frame();
    in_valid  = 1'b1;
    win_ready = 1'b0;
    for (int i = 0; i < 40 && !win_valid; i++) begin
      win_ready = 1'b1;
      @(posedge clk); #1;
      win_ready = 1'b0;
    end
    check("pre_rst_valid", 32'(win_valid), 1);
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check("mid_rst_ready", 32'(in_ready), 0);
    check("mid_rst_valid", 32'(win_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_pos", cur_pos, 0);
    @(posedge clk); #1;
    rst        = 1'b0;
    in_valid   = 1'b0;
    win_ready  = 1'b1;
    prev_valid = 1'b0;
    exp_flag   = 1'b0;
    last_acc   = 1'b0;
    mon_en     = 1'b1;
    run_frame(100, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
